// File: rtl/pipeline_cpu_4stage.sv
// Minimal 8-bit four-stage (IF/ID/EX/WB) in-order CPU with private imem, register file and dmem.
// No stalls or branches; forwarding covers dependency distances one and two.
module pipeline_cpu_4stage #(
   parameter int unsigned IMEM_DEPTH = 16,
   parameter int unsigned DMEM_DEPTH = 4
) (
   input logic clk,
   input logic rst
);

   localparam int unsigned XLEN = 8;
   localparam int unsigned PC_W = $clog2(IMEM_DEPTH);
   localparam int unsigned RI_W = 2;

   localparam logic [1:0] OP_ADD  = 2'b00;
   localparam logic [1:0] OP_SUB  = 2'b01;
   localparam logic [1:0] OP_LOAD = 2'b10;

   logic [XLEN-1:0] imem    [0:IMEM_DEPTH-1];
   logic [XLEN-1:0] regfile [0:3];
   logic [XLEN-1:0] dmem    [0:DMEM_DEPTH-1];

   logic [PC_W-1:0] pc;

   logic [XLEN-1:0] ifid_instr;
   logic            ifid_valid;

   logic [1:0]      idex_opcode;
   logic [RI_W-1:0] idex_rd;
   logic [RI_W-1:0] idex_rs1;
   logic [RI_W-1:0] idex_rs2;
   logic [1:0]      idex_addr;
   logic [XLEN-1:0] idex_a;
   logic [XLEN-1:0] idex_b;
   logic            idex_we;

   logic [RI_W-1:0] exwb_rd;
   logic [XLEN-1:0] exwb_result;
   logic            exwb_we;

   logic [1:0]      id_opcode_c;
   logic [RI_W-1:0] id_rd_c;
   logic [RI_W-1:0] id_rs1_c;
   logic [RI_W-1:0] id_rs2_c;
   logic            id_we_c;
   logic [XLEN-1:0] id_a_c;
   logic [XLEN-1:0] id_b_c;
   logic [XLEN-1:0] ex_a_c;
   logic [XLEN-1:0] ex_b_c;
   logic [XLEN-1:0] ex_result_c;

   // Decode plus register read with write-through bypass from the instruction being retired.
   always_comb begin
      id_opcode_c = ifid_instr[7:6];
      id_rd_c     = ifid_instr[5:4];
      id_rs1_c    = ifid_instr[3:2];
      id_rs2_c    = ifid_instr[1:0];
      id_we_c     = 1'b0;
      // Unknown opcodes fall to default so uninitialised program words never write.
      case (id_opcode_c)
         OP_ADD, OP_SUB, OP_LOAD: id_we_c = ifid_valid;
         default:                 id_we_c = 1'b0;
      endcase
      id_a_c = (exwb_we && exwb_rd == id_rs1_c) ? exwb_result : regfile[id_rs1_c];
      id_b_c = (exwb_we && exwb_rd == id_rs2_c) ? exwb_result : regfile[id_rs2_c];
   end

   // Execute with operand forwarding from the previous instruction.
   always_comb begin
      ex_a_c      = (exwb_we && exwb_rd == idex_rs1) ? exwb_result : idex_a;
      ex_b_c      = (exwb_we && exwb_rd == idex_rs2) ? exwb_result : idex_b;
      ex_result_c = '0;
      case (idex_opcode)
         OP_ADD:  ex_result_c = ex_a_c + ex_b_c;
         OP_SUB:  ex_result_c = ex_a_c - ex_b_c;
         OP_LOAD: ex_result_c = dmem[idex_addr];
         default: ex_result_c = '0;
      endcase
   end

   // Pipeline registers and program counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc          <= '0;
         ifid_instr  <= '0;
         ifid_valid  <= 1'b0;
         idex_opcode <= '0;
         idex_rd     <= '0;
         idex_rs1    <= '0;
         idex_rs2    <= '0;
         idex_addr   <= '0;
         idex_a      <= '0;
         idex_b      <= '0;
         idex_we     <= 1'b0;
         exwb_rd     <= '0;
         exwb_result <= '0;
         exwb_we     <= 1'b0;
      end else begin
         pc          <= (pc == PC_W'(IMEM_DEPTH - 1)) ? '0 : pc + PC_W'(1);
         ifid_instr  <= imem[pc];
         ifid_valid  <= 1'b1;
         idex_opcode <= id_opcode_c;
         idex_rd     <= id_rd_c;
         idex_rs1    <= id_rs1_c;
         idex_rs2    <= id_rs2_c;
         idex_addr   <= ifid_instr[1:0];
         idex_a      <= id_a_c;
         idex_b      <= id_b_c;
         idex_we     <= id_we_c;
         exwb_rd     <= idex_rd;
         exwb_result <= ex_result_c;
         exwb_we     <= idex_we;
      end
   end

   // Writeback; register contents survive reset.
   always_ff @(posedge clk) begin
      if (!rst && exwb_we) regfile[exwb_rd] <= exwb_result;
   end

endmodule

// File: tb/tb_pipeline_cpu_4stage.sv
// Directed bench for pipeline_cpu_4stage: programs preloaded hierarchically, registers checked per edge.
module tb_pipeline_cpu_4stage;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int n_checks = 0;
   int n_errors = 0;

   pipeline_cpu_4stage dut (
      .clk(clk),
      .rst(rst)
   );

   always #5 clk = ~clk;

   task automatic check8(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0d (0x%h) exp=%0d (0x%h)", tag, got, got, exp, exp);
      end
   endtask

   // Enter reset and fill the program with NOPs; caller preloads while reset is held.
   task automatic begin_test();
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 16; i++) dut.imem[i] = 8'hFF;
   endtask

   task automatic set_regs(input logic [7:0] r0, input logic [7:0] r1,
                           input logic [7:0] r2, input logic [7:0] r3);
      dut.regfile[0] = r0;
      dut.regfile[1] = r1;
      dut.regfile[2] = r2;
      dut.regfile[3] = r3;
   endtask

   task automatic release_rst();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic edges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      // Basic program with latency checks
      begin_test();
      set_regs(8'd0, 8'd5, 8'd3, 8'd2);
      dut.dmem[0] = 8'h11; dut.dmem[1] = 8'h22; dut.dmem[2] = 8'h33; dut.dmem[3] = 8'd99;
      dut.imem[0] = 8'h06;   // ADD R0 = R1 + R2
      dut.imem[1] = 8'h5B;   // SUB R1 = R2 - R3
      dut.imem[2] = 8'hA3;   // LOAD R2 = dmem[3]
      #1;
      check8("rst_pc", 8'(dut.pc), 8'd0);
      check8("rst_ifid_valid", 8'(dut.ifid_valid), 8'd0);
      check8("rst_idex_we", 8'(dut.idex_we), 8'd0);
      check8("rst_exwb_we", 8'(dut.exwb_we), 8'd0);
      release_rst();
      edges(3);
      check8("basic_e3_r0", dut.regfile[0], 8'd0);
      edges(1);
      check8("basic_e4_r0", dut.regfile[0], 8'd8);
      check8("basic_e4_r1", dut.regfile[1], 8'd5);
      edges(1);
      check8("basic_e5_r1", dut.regfile[1], 8'd1);
      check8("basic_e5_r2", dut.regfile[2], 8'd3);
      edges(1);
      check8("basic_e6_r2", dut.regfile[2], 8'd99);
      edges(4);
      check8("basic_end_r0", dut.regfile[0], 8'd8);
      check8("basic_end_r1", dut.regfile[1], 8'd1);
      check8("basic_end_r2", dut.regfile[2], 8'd99);
      check8("basic_end_r3", dut.regfile[3], 8'd2);
      check8("basic_end_dmem3", dut.dmem[3], 8'd99);
      check8("basic_end_pc", 8'(dut.pc), 8'd10);

      // Forwarding distance 1, 2 and 3
      begin_test();
      set_regs(8'd0, 8'd5, 8'd3, 8'd2);
      dut.imem[0] = 8'h06;   // ADD R0 = R1 + R2       -> 8
      dut.imem[1] = 8'h73;   // SUB R3 = R0 - R3       -> 6
      dut.imem[2] = 8'h13;   // ADD R1 = R0 + R3       -> 14
      dut.imem[3] = 8'h20;   // ADD R2 = R0 + R0       -> 16
      release_rst();
      edges(8);
      check8("fwd_r0", dut.regfile[0], 8'd8);
      check8("fwd_r3", dut.regfile[3], 8'd6);
      check8("fwd_r1", dut.regfile[1], 8'd14);
      check8("fwd_r2", dut.regfile[2], 8'd16);

      // Modulo-256 wrap on ADD and SUB
      begin_test();
      set_regs(8'd2, 8'd250, 8'd10, 8'd5);
      dut.imem[0] = 8'h73;   // SUB R3 = R0 - R3 = 2 - 5
      dut.imem[1] = 8'h16;   // ADD R1 = R1 + R2 = 250 + 10
      release_rst();
      edges(6);
      check8("wrap_sub_r3", dut.regfile[3], 8'd253);
      check8("wrap_add_r1", dut.regfile[1], 8'd4);
      check8("wrap_r0", dut.regfile[0], 8'd2);

      // NOP encodings and LOAD using the literal address field
      begin_test();
      set_regs(8'd1, 8'd2, 8'd3, 8'd4);
      dut.dmem[0] = 8'h5A; dut.dmem[1] = 8'h77;
      dut.imem[0] = 8'hFF;
      dut.imem[1] = 8'hC5;   // opcode 11 with nonzero fields
      dut.imem[2] = 8'hB0;   // LOAD R3 = dmem[0]
      release_rst();
      edges(5);
      check8("nop_r0", dut.regfile[0], 8'd1);
      check8("nop_r1", dut.regfile[1], 8'd2);
      check8("nop_r2", dut.regfile[2], 8'd3);
      check8("nop_r3", dut.regfile[3], 8'd4);
      edges(1);
      check8("load_r3", dut.regfile[3], 8'h5A);

      // Reset with three instructions in flight
      begin_test();
      set_regs(8'd0, 8'd5, 8'd3, 8'd2);
      dut.imem[0] = 8'h06;   // ADD R0 = R1 + R2 -> 8
      dut.imem[1] = 8'h35;   // ADD R3 = R1 + R1 -> 10
      dut.imem[2] = 8'h25;   // ADD R2 = R1 + R1 -> 10
      release_rst();
      edges(3);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check8("midrst_pc", 8'(dut.pc), 8'd0);
      check8("midrst_exwb_we", 8'(dut.exwb_we), 8'd0);
      edges(3);
      check8("midrst_r0", dut.regfile[0], 8'd0);
      check8("midrst_r3", dut.regfile[3], 8'd2);
      check8("midrst_r2", dut.regfile[2], 8'd3);
      release_rst();
      edges(4);
      check8("rerun_r0", dut.regfile[0], 8'd8);
      edges(2);
      check8("rerun_r3", dut.regfile[3], 8'd10);
      check8("rerun_r2", dut.regfile[2], 8'd10);

      // PC wrap with a chain of dependent increments
      begin_test();
      set_regs(8'd0, 8'd1, 8'd0, 8'd0);
      for (int i = 0; i < 16; i++) dut.imem[i] = 8'h01;   // ADD R0 = R0 + R1
      release_rst();
      edges(19);
      check8("pcwrap_e19_r0", dut.regfile[0], 8'd16);
      check8("pcwrap_e19_pc", 8'(dut.pc), 8'd3);
      edges(4);
      check8("pcwrap_e23_r0", dut.regfile[0], 8'd20);
      check8("pcwrap_e23_pc", 8'(dut.pc), 8'd7);
      check8("pcwrap_r1", dut.regfile[1], 8'd1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
